// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite motion controller.
//   mode_t      - wall behaviour selected by the 2-bit mode input
//   state_t     - motion state (IDLE / MOVE)
//   KEY_*       - USB HID keycodes recognised by the key decoder
//   decode_mode - maps the raw 2-bit mode input onto mode_t (11 -> BOUNCE)
package sprite_pkg;

  typedef enum logic [1:0] {
    BOUNCE = 2'b00,
    WRAP   = 2'b01,
    STOP   = 2'b10
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  localparam logic [7:0] KEY_A     = 8'h04;  // left
  localparam logic [7:0] KEY_D     = 8'h07;  // right
  localparam logic [7:0] KEY_S     = 8'h16;  // down
  localparam logic [7:0] KEY_W     = 8'h1A;  // up
  localparam logic [7:0] KEY_SPACE = 8'h2C;  // stop
  localparam logic [7:0] KEY_NONE  = 8'h00;  // "no direction key seen yet"

  // Unused encoding 11 falls back to bounce.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'b01:   m = WRAP;
      2'b10:   m = STOP;
      default: m = BOUNCE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sprite_axis.sv
// sprite_axis: combinational per-axis candidate / wall logic.
//   pos      in  W  current centre position (unsigned)
//   m        in  W  motion decided this frame (two's complement)
//   min_pos  in  W  lowest legal pixel on this axis
//   max_pos  in  W  highest legal pixel on this axis
//   size     in  W  sprite half-width
//   mode     in     wall behaviour
//   next_pos out W  position to register this frame
//   next_m   out W  motion to register (before any global stop)
//   hit      out 1  a wall condition triggered on this axis
//   stop_req out 1  stop-mode wall hit: both axes must halt
import sprite_pkg::*;

module sprite_axis #(
  parameter int W = 10
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] m,
  input  logic [W-1:0] min_pos,
  input  logic [W-1:0] max_pos,
  input  logic [W-1:0] size,
  input  mode_t        mode,
  output logic [W-1:0] next_pos,
  output logic [W-1:0] next_m,
  output logic         hit,
  output logic         stop_req
);

  // Two extra bits: one for sign, one for headroom, so pos+m never wraps.
  localparam int CW = W + 2;

  logic signed [CW-1:0] cand_s;
  logic signed [CW-1:0] lo_lim_s;
  logic signed [CW-1:0] hi_lim_s;
  logic [W-1:0]         lo_pos_s;
  logic [W-1:0]         hi_pos_s;
  logic [W-1:0]         neg_m_s;

  assign cand_s   = $signed({2'b00, pos}) + $signed({{2{m[W-1]}}, m});
  // c - SIZE < MIN  <=>  c < MIN + SIZE ;  c + SIZE > MAX  <=>  c > MAX - SIZE
  assign lo_lim_s = $signed({2'b00, min_pos}) + $signed({2'b00, size});
  assign hi_lim_s = $signed({2'b00, max_pos}) - $signed({2'b00, size});
  assign lo_pos_s = min_pos + size;
  assign hi_pos_s = max_pos - size;
  assign neg_m_s  = {W{1'b0}} - m;

  // Wall detection and mode-dependent resolution.
  always_comb begin
    next_pos = cand_s[W-1:0];
    next_m   = m;
    hit      = 1'b0;
    stop_req = 1'b0;
    if (cand_s < lo_lim_s) begin
      hit = 1'b1;
      case (mode)
        WRAP: begin
          next_pos = hi_pos_s;
        end
        STOP: begin
          next_pos = lo_pos_s;
          next_m   = {W{1'b0}};
          stop_req = 1'b1;
        end
        default: begin
          next_pos = lo_pos_s;
          next_m   = neg_m_s;
        end
      endcase
    end else if (cand_s > hi_lim_s) begin
      hit = 1'b1;
      case (mode)
        WRAP: begin
          next_pos = lo_pos_s;
        end
        STOP: begin
          next_pos = hi_pos_s;
          next_m   = {W{1'b0}};
          stop_req = 1'b1;
        end
        default: begin
          next_pos = hi_pos_s;
          next_m   = neg_m_s;
        end
      endcase
    end else begin
      next_pos = cand_s[W-1:0];
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame motion controller for a square sprite.
//   frame_clk in  1  frame-rate clock (vsync derived)
//   Reset     in  1  synchronous active-low reset
//   keycode   in  8  USB HID keycode, sampled every frame
//   mode      in  2  wall mode: 00 bounce, 01 wrap, 10 stop, 11 bounce
//   ObjX/ObjY out W  registered sprite centre
//   ObjS      out W  constant half-width
//   MotionX/Y out W  registered two's complement velocity
//   edge_hit  out 1  one-frame pulse when any wall condition fired
// The motion decided from this frame's key is applied to the position in the
// same frame, so there is no stale-motion step into a wall.
import sprite_pkg::*;

module sprite_mover #(
  parameter int W            = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int SIZE         = 4,
  parameter int STEP_MIN     = 1,
  parameter int STEP_MAX     = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   keycode,
  input  logic [1:0]   mode,
  output logic [W-1:0] ObjX,
  output logic [W-1:0] ObjY,
  output logic [W-1:0] ObjS,
  output logic [W-1:0] MotionX,
  output logic [W-1:0] MotionY,
  output logic         edge_hit
);

  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [W-1:0]     SPD_MIN  = W'(STEP_MIN);
  localparam logic [W-1:0]     SPD_MAX  = W'(STEP_MAX);

  logic [W-1:0]     pos_x_r, pos_y_r, motion_x_r, motion_y_r, speed_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       last_key_r;
  state_t           state_r;
  logic             edge_hit_r;

  logic [W-1:0]     speed_s, key_mx_s, key_my_s;
  logic [CNT_W-1:0] cnt_s;
  logic [7:0]       last_key_s;
  state_t           state_key_s, state_s;
  logic             is_dir_s;
  logic [W-1:0]     ax_pos_x_s, ax_pos_y_s, ax_m_x_s, ax_m_y_s;
  logic [W-1:0]     motion_x_s, motion_y_s;
  logic             hit_x_s, hit_y_s, stop_x_s, stop_y_s;
  mode_t            mode_s;

  assign mode_s   = decode_mode(mode);
  assign is_dir_s = (keycode == KEY_A) || (keycode == KEY_D) ||
                    (keycode == KEY_S) || (keycode == KEY_W);

  // Key decoder, speed/hold-counter update and key-driven motion.
  always_comb begin
    speed_s     = speed_r;
    cnt_s       = cnt_r;
    last_key_s  = last_key_r;
    key_mx_s    = motion_x_r;
    key_my_s    = motion_y_r;
    state_key_s = state_r;
    if (keycode == KEY_SPACE) begin
      key_mx_s    = {W{1'b0}};
      key_my_s    = {W{1'b0}};
      speed_s     = SPD_MIN;
      cnt_s       = {CNT_W{1'b0}};
      state_key_s = IDLE;
    end else if (is_dir_s) begin
      last_key_s  = keycode;
      state_key_s = MOVE;
      if (keycode != last_key_r) begin
        speed_s = SPD_MIN;
        cnt_s   = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_s   = {CNT_W{1'b0}};
        speed_s = (speed_r >= SPD_MAX) ? SPD_MAX : speed_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // Down is +Y (screen coordinates), up is -Y.
      case (keycode)
        KEY_A: begin
          key_mx_s = {W{1'b0}} - speed_s;
          key_my_s = {W{1'b0}};
        end
        KEY_D: begin
          key_mx_s = speed_s;
          key_my_s = {W{1'b0}};
        end
        KEY_S: begin
          key_mx_s = {W{1'b0}};
          key_my_s = speed_s;
        end
        KEY_W: begin
          key_mx_s = {W{1'b0}};
          key_my_s = {W{1'b0}} - speed_s;
        end
        default: begin
          key_mx_s = motion_x_r;
          key_my_s = motion_y_r;
        end
      endcase
    end else begin
      // Coast: every field keeps its registered value (defaults above).
      state_key_s = state_r;
    end
  end

  sprite_axis #(.W(W)) u_axis_x (
    .pos      (pos_x_r),
    .m        (key_mx_s),
    .min_pos  (W'(X_MIN)),
    .max_pos  (W'(X_MAX)),
    .size     (W'(SIZE)),
    .mode     (mode_s),
    .next_pos (ax_pos_x_s),
    .next_m   (ax_m_x_s),
    .hit      (hit_x_s),
    .stop_req (stop_x_s)
  );

  sprite_axis #(.W(W)) u_axis_y (
    .pos      (pos_y_r),
    .m        (key_my_s),
    .min_pos  (W'(Y_MIN)),
    .max_pos  (W'(Y_MAX)),
    .size     (W'(SIZE)),
    .mode     (mode_s),
    .next_pos (ax_pos_y_s),
    .next_m   (ax_m_y_s),
    .hit      (hit_y_s),
    .stop_req (stop_y_s)
  );

  // FSM next state and final motion: a stop-mode wall on either axis halts both.
  always_comb begin
    motion_x_s = ax_m_x_s;
    motion_y_s = ax_m_y_s;
    state_s    = state_key_s;
    if (stop_x_s || stop_y_s) begin
      motion_x_s = {W{1'b0}};
      motion_y_s = {W{1'b0}};
      state_s    = IDLE;
    end else begin
      state_s    = state_key_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      pos_x_r    <= W'(X_CENTER);
      pos_y_r    <= W'(Y_CENTER);
      motion_x_r <= {W{1'b0}};
      motion_y_r <= {W{1'b0}};
      speed_r    <= SPD_MIN;
      cnt_r      <= {CNT_W{1'b0}};
      last_key_r <= KEY_NONE;
      state_r    <= IDLE;
      edge_hit_r <= 1'b0;
    end else begin
      pos_x_r    <= ax_pos_x_s;
      pos_y_r    <= ax_pos_y_s;
      motion_x_r <= motion_x_s;
      motion_y_r <= motion_y_s;
      speed_r    <= speed_s;
      cnt_r      <= cnt_s;
      last_key_r <= last_key_s;
      state_r    <= state_s;
      edge_hit_r <= hit_x_s | hit_y_s;
    end
  end

  assign ObjX     = pos_x_r;
  assign ObjY     = pos_y_r;
  assign ObjS     = W'(SIZE);
  assign MotionX  = motion_x_r;
  assign MotionY  = motion_y_r;
  assign edge_hit = edge_hit_r;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised per-frame motion controller for a square on-screen sprite. Next generation of the single-ball mover.
- Adds configurable bounds, size and width, plus three edge modes: bounce, wrap and stop.
- Adds keyboard-driven acceleration while a direction key is held, and a stop key.
- Position updates use the motion decided in the same frame, so there is no one-frame stale-motion overshoot at walls.
- Feeds X/Y/size to the colour mapper. Clocked once per VGA frame (vsync-derived).

Parameters:
- W, 10, width of position/size outputs
- X_MIN, 0, leftmost legal pixel
- X_MAX, 639, rightmost legal pixel
- Y_MIN, 0, topmost legal pixel
- Y_MAX, 479, bottommost legal pixel
- X_CENTER, 320, reset X position
- Y_CENTER, 240, reset Y position
- SIZE, 4, half-width of sprite
- STEP_MIN, 1, initial speed in pixels/frame
- STEP_MAX, 4, saturating top speed
- ACCEL_FRAMES, 8, consecutive held frames per +1 speed

Ports:
- frame_clk  in  1  frame-rate clock; the single clock
- Reset  in  1  synchronous, active-low reset
- keycode  in  8  USB HID keycode, sampled each frame_clk edge
- mode  in  2  edge mode: 00 bounce, 01 wrap, 10 stop, 11 treated as bounce
- ObjX  out  W  registered centre X
- ObjY  out  W  registered centre Y
- ObjS  out  W  constant SIZE
- MotionX  out  W  registered signed X velocity (two's complement)
- MotionY  out  W  registered signed Y velocity (two's complement)
- edge_hit  out  1  one-frame pulse when any wall condition triggered this frame

Behaviour:
- Reset (Reset==0 at a frame_clk edge, including mid-motion): ObjX=X_CENTER, ObjY=Y_CENTER, MotionX=MotionY=0, speed=STEP_MIN, hold counter=0, last_key=none, state=IDLE, edge_hit=0.
- Key decode:
  - 0x04 → left; 0x07 → right; 0x16 → down; 0x1A → up.
  - 0x2C → stop: both motions become 0, state goes to IDLE, speed resets to STEP_MIN.
  - Any other code, including 0x00 → coast: keep current motion, speed and state.
- Direction keys move only one axis: the other axis motion becomes 0, and state goes to MOVE.
- Speed:
  - A direction key differing from last_key sets speed=STEP_MIN and counter=0.
  - The same key held increments the counter. When counter reaches ACCEL_FRAMES-1, the counter clears and speed increments, saturating at STEP_MAX.
  - Coast frames freeze both counter and speed.
  - last_key updates only on direction keys.
- Per-axis next motion m = key-selected ±speed, otherwise the current motion.
- Candidate position is computed as c = pos + m, in signed W+2 bits; there is no unsigned underflow.
- Edge handling, low side (c - SIZE < MIN):
  - bounce: pos = MIN+SIZE, m = -m
  - wrap: pos = MAX-SIZE, m kept
  - stop: pos = MIN+SIZE, both motions 0, state IDLE
- Edge handling, high side (c + SIZE > MAX), mirrored:
  - bounce: pos = MAX-SIZE, m = -m
  - wrap: pos = MIN+SIZE, m kept
  - stop: pos = MAX-SIZE, both motions 0, state IDLE
- Any edge condition on either axis drives edge_hit=1 for that frame only.
- If no edge condition: pos = c.
- A key pushing into a wall is subject to the same edge rule. In bounce mode the reversed motion is registered, and the next held frame re-asserts the key.
- Latency: keycode at edge k is reflected in ObjX/ObjY at edge k, using the new motion; there is no extra frame.
- A mode change takes effect at the next edge. Motion is not altered by the mode change itself.
- State machine:
  - IDLE: motions are 0; a direction key moves to MOVE.
  - MOVE: the stop key or a stop-mode edge moves to IDLE.
- All outputs are registered. ObjS is a constant.

Decomposition:
- sprite_pkg holds:
  - mode_t enum (BOUNCE, WRAP, STOP)
  - state_t enum (IDLE, MOVE)
  - keycode constants KEY_A, KEY_D, KEY_S, KEY_W, KEY_SPACE
- Sub-module sprite_axis, instantiated for X and Y.
  - Combinational candidate, edge and mode logic.
  - Inputs: pos, m, MIN, MAX, SIZE, mode.
  - Outputs: next pos, next motion, hit, stop_req.
- Top level holds the key decoder, speed/counter logic, FSM and registers.

Test Plan:
- Reset=0 one edge, then keycode=0x00 → ObjX=320, ObjY=240, MotionX=MotionY=0, edge_hit=0.
- keycode=0x07 for 1 edge → ObjX=321, MotionX=1. Hold 0x07 for 9 edges from reset → MotionX=2 at edge 9, ObjX=330.
- X_MAX=335, ACCEL_FRAMES=64, bounce: hold 0x07 until ObjX=331. Next edge → ObjX=331, MotionX=-1, edge_hit=1. Then keycode=0x00 → ObjX=330, edge_hit=0.
- Same setup, mode=01: next edge from ObjX=331 → ObjX=4, MotionX=+1, edge_hit=1.
- Same setup, mode=10: next edge from ObjX=331 → ObjX=331, MotionX=0, state IDLE. Then keycode=0x00 → ObjX stays 331.
- Moving up at speed 1 from Y=240: keycode=0x2C → ObjY=240, MotionY=0. Then Reset=0 while MotionX=3 → ObjX=320, MotionX=0 at that edge.
